// File: rtl/result_uart_streamer.sv
// Streams the N x N result matrix over a UART 8N1 line: header 0xA5, each element
// MSB byte first, then the XOR of all payload bytes. Drives the TX pin from a register.
module result_uart_streamer #(
    parameter int N            = 4,
    parameter int ELEM_W       = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [ELEM_W-1:0] rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int BYTES  = ELEM_W / 8;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);

    localparam logic [7:0]        HEADER    = 8'hA5;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_LATCH, S_BYTES, S_CKSUM, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP
    } bit_state_t;

    state_t            state_q, state_d;
    bit_state_t        bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic [BCNT_W-1:0] byte_q, byte_d;
    logic [7:0]        cksum_q, cksum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tx_q, tx_d;

    logic              load;
    logic [7:0]        load_byte;
    logic              frame_end;

    assign frame_end = (bit_q == BIT_STOP) && (cnt_q == LAST_CNT);

    // Outer sequencer: decides which byte the bit engine sends next. Bytes are
    // folded into the checksum as they are handed over, so the running value
    // is already complete when the last element byte leaves.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        elem_d    = elem_q;
        byte_d    = byte_q;
        cksum_d   = cksum_q;
        load      = 1'b0;
        load_byte = HEADER;

        unique case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start) begin
                    load    = 1'b1;
                    cksum_d = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (frame_end) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                load      = 1'b1;
                load_byte = rd_data[ELEM_W-1 -: 8];
                elem_d    = rd_data << 8;
                byte_d    = '0;
                cksum_d   = cksum_q ^ rd_data[ELEM_W-1 -: 8];
                state_d   = S_BYTES;
            end
            S_BYTES: begin
                if (frame_end) begin
                    if (byte_q != LAST_BYTE) begin
                        load      = 1'b1;
                        load_byte = elem_q[ELEM_W-1 -: 8];
                        elem_d    = elem_q << 8;
                        byte_d    = byte_q + 1'b1;
                        cksum_d   = cksum_q ^ elem_q[ELEM_W-1 -: 8];
                    end else if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        load      = 1'b1;
                        load_byte = cksum_q;
                        state_d   = S_CKSUM;
                    end
                end
            end
            S_CKSUM: begin
                if (frame_end) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bit engine: start bit, eight data bits LSB first, stop bit. A load on the
    // stop bit's final cycle starts the next frame with no idle gap.
    always_comb begin
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;

        if (bit_q != BIT_IDLE) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end

        unique case (bit_q)
            BIT_START: begin
                if (cnt_q == LAST_CNT) begin
                    bit_d     = BIT_DATA;
                    bit_idx_d = '0;
                end
            end
            BIT_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_d = BIT_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            BIT_STOP: begin
                if (cnt_q == LAST_CNT) bit_d = BIT_IDLE;
            end
            default: bit_d = BIT_IDLE;
        endcase

        if (load) begin
            bit_d   = BIT_START;
            cnt_d   = '0;
            shift_d = load_byte;
        end

        unique case (bit_d)
            BIT_START: tx_d = 1'b0;
            BIT_DATA:  tx_d = shift_d[0];
            default:   tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous and overrides all state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_q     <= BIT_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            elem_q    <= '0;
            byte_q    <= '0;
            cksum_q   <= '0;
            addr_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            elem_q    <= elem_d;
            byte_q    <= byte_d;
            cksum_q   <= cksum_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
        end
    end

    assign rd_addr = addr_q;
    assign tx      = tx_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);

endmodule

// File: doc/result_uart_streamer.md
# result_uart_streamer

Downstream transmit stage of the matrix-multiply datapath. On a start pulse it reads the N×N result matrix from the result buffer in row-major order and serialises it over a UART 8N1 line to the Raspberry Pi: one header byte, each element big-endian in ELEM_W/8 bytes, then an XOR checksum byte. It implements the top-level S_TRANSMIT phase and drives the JA[4] TX pin directly.

## Interface
Parameters:
- N, 4, matrix dimension; result has N*N elements.
- ELEM_W, 32, element width in bits; must be a multiple of 8.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- ADDR_W, $clog2(N*N) (min 1), result buffer address width.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a transfer; ignored while busy.
- rd_addr, output, ADDR_W, result buffer read address.
- rd_data, input, ELEM_W, result buffer data; valid on the cycle after rd_addr is presented (1-cycle synchronous read).
- tx, output, 1, UART TX line; idle high.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, single-cycle pulse after the final stop bit completes.

## Operation
- Reset values: tx=1, busy=0, done=0, rd_addr=0. Reset is synchronous and overrides every state, including mid-frame; if rst_n=0 coincides with start, reset wins.
- Frame format: start bit 0, eight data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- Byte stream per transfer: 0xA5, then elements 0 to N*N-1 (index = row*N+col), each MSB byte first, then the checksum. The checksum is the XOR of all payload bytes; it excludes the header.
- Total frames = 2 + N*N*(ELEM_W/8).
- Outer FSM:
  - S_IDLE: on start, set busy, load 0xA5, go to S_HDR.
  - S_HDR: send the header. After the stop bit, drive rd_addr=0 and go to S_FETCH.
  - S_FETCH: one cycle, waits for read latency; go to S_LATCH.
  - S_LATCH: capture rd_data into the shift register, clear the byte counter, go to S_BYTES.
  - S_BYTES: send ELEM_W/8 frames back-to-back, XORing each byte into the checksum. After the last stop bit:
    - if elem_idx < N*N-1: increment rd_addr and go to S_FETCH;
    - otherwise go to S_CKSUM.
  - S_CKSUM: send the checksum byte, then go to S_DONE.
  - S_DONE: pulse done for one cycle, clear busy, return to S_IDLE.
- Bit engine sub-states: BIT_START, BIT_DATA (3-bit bit index), BIT_STOP. It has a cycle counter from 0 to CLKS_PER_BIT-1 and accepts a new byte only when its stop bit completes or it is idle.
- The checksum register is cleared on start acceptance.
- tx is registered with no combinational path from inputs. tx is 1 in every state except during a start bit or a 0 data bit.

## Timing
- start accepted in cycle T (S_IDLE, start=1): busy=1 at T+1, and tx falls at T+1 (header start bit).
- Within an element, byte frames are back-to-back: the next start bit begins on the cycle immediately after the previous stop bit's last cycle.
- Between elements, and between the header and the first element, there are exactly 2 idle-high cycles (S_FETCH, S_LATCH). The checksum follows the last element byte with 0 idle cycles.
- done is asserted on the cycle after the checksum stop bit's last cycle; busy falls on the same edge.
- Total transfer length from T+1 to done: 10*CLKS_PER_BIT*(2+N*N*ELEM_W/8) + 2*N*N cycles.
- rd_addr holds stable from S_FETCH through S_LATCH. It is never driven beyond N*N-1 and wraps to 0 in S_IDLE.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start pulsed → tx=1, busy=0, done=0, rd_addr=0 throughout; no frame emitted.
- Minimal transfer (N=1, ELEM_W=8, CLKS_PER_BIT=4, element 0x3C) → frames 0xA5, 0x3C, 0x3C; each frame is 40 cycles; done is high exactly at T+1+120+2.
- Full 4×4 (ELEM_W=32, CLKS_PER_BIT=4), element k = 0x0102_0300+k → 66 frames. Element 5 is sent as 01 02 03 05. Checksum is the XOR of all 64 payload bytes. Gaps between elements are exactly 2 cycles.
- Start while busy: pulse start mid-transfer → stream unchanged, no second header, a single done pulse.
- Reset mid-frame: assert rst_n=0 during data bit 3 of element 2 → tx=1 on the next edge and busy=0. A fresh start then produces a complete stream beginning with 0xA5, with a checksum not contaminated by the aborted transfer.
- Back-to-back transfers: start on the cycle after done → second stream is identical to the first, with its checksum recomputed from zero.
